// File: rtl/uncached_wr_arb_pkg.sv
// Shared types for the uncached write arbiter: FSM state, latched store
// payload, count width and the in-flight counter update helper.
package uncached_wr_arb_pkg;

  localparam int CntWidth        = 4;
  localparam int MaxAddrWidth    = 64;
  localparam int MaxDataWidth    = 64;
  localparam int MaxHartIdxWidth = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } uncached_wr_arb_state_e;

  // Payload is held at maximum width; the top uses the low bits it needs.
  typedef struct packed {
    logic [MaxAddrWidth-1:0]    addr;
    logic [MaxDataWidth-1:0]    data;
    logic [MaxDataWidth/8-1:0]  be;
    logic [MaxHartIdxWidth-1:0] hart;
  } uncached_wr_payload_t;

  // In-flight counter update: an AW launch and a B completion in the same
  // cycle cancel out.
  function automatic logic [CntWidth-1:0] cnt_next(input logic [CntWidth-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
    logic [CntWidth-1:0] res;
    res = cnt;
    if (inc && !dec) res = cnt + 1'b1;
    else if (dec && !inc) res = cnt - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/uncached_wr_arb_if.sv
// Hart store requests, completions and the AXI AW/W/B subset of the
// uncached write arbiter. The master modport is the arbiter's view, the
// slave modport is the view of the harts plus the AXI fabric.
interface uncached_wr_arb_if #(
  parameter int NrHarts    = 2,
  parameter int AxiIdWidth = 4,
  parameter int AddrWidth  = 64,
  parameter int DataWidth  = 64
);
  logic [NrHarts-1:0]                  req_valid_i;
  logic [NrHarts-1:0]                  req_ready_o;
  logic [NrHarts-1:0][AddrWidth-1:0]   req_addr_i;
  logic [NrHarts-1:0][DataWidth-1:0]   req_data_i;
  logic [NrHarts-1:0][DataWidth/8-1:0] req_be_i;
  logic [NrHarts-1:0]                  rsp_valid_o;
  logic                                rsp_err_o;

  logic                   aw_valid_o;
  logic                   aw_ready_i;
  logic [AddrWidth-1:0]   aw_addr_o;
  logic [AxiIdWidth-1:0]  aw_id_o;
  logic [7:0]             aw_len_o;

  logic                   w_valid_o;
  logic                   w_ready_i;
  logic [DataWidth-1:0]   w_data_o;
  logic [DataWidth/8-1:0] w_strb_o;
  logic                   w_last_o;

  logic                   b_valid_i;
  logic                   b_ready_o;
  logic [AxiIdWidth-1:0]  b_id_i;
  logic [1:0]             b_resp_i;

  logic [3:0]             outstanding_o;

  modport master (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i,
    output req_ready_o, rsp_valid_o, rsp_err_o,
    output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o,
    input  aw_ready_i,
    output w_valid_o, w_data_o, w_strb_o, w_last_o,
    input  w_ready_i,
    input  b_valid_i, b_id_i, b_resp_i,
    output b_ready_o,
    output outstanding_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_data_i, req_be_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o,
    input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o,
    output aw_ready_i,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o,
    output w_ready_i,
    output b_valid_i, b_id_i, b_resp_i,
    input  b_ready_o,
    input  outstanding_o
  );
endinterface

// File: rtl/uncached_wr_arb_rr_grant.sv
// Round-robin grant: combinational pick of the first requester at or after
// the priority pointer; the pointer moves past the winner only when the
// grant is actually taken, wrapping from NrHarts-1 to 0.
module rr_grant #(
  parameter int NrHarts = 2,
  parameter int IdxW    = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NrHarts-1:0] req_i,
  input  logic               take_i,
  output logic               gnt_valid_o,
  output logic [IdxW-1:0]    gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;

  // Search requesters starting at the pointer, first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    gnt_idx_o   = '0;
    for (int i = 0; i < NrHarts; i++) begin
      idx = (int'(ptr_q) + i) % NrHarts;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = IdxW'(idx);
      end
    end
    gnt_valid_o = found;
  end

  // Advance priority to the hart after the winner on each taken grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (take_i) begin
      ptr_q <= (gnt_idx_o == IdxW'(NrHarts - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/uncached_wr_arb.sv
// Uncached write arbiter: round-robin selects one hart store at a time,
// issues it as a single-beat AXI write (AW and W in parallel) and tracks
// writes in flight up to MaxOutstanding. B beats are routed back to the
// issuing hart by AXI id.
// Optional feature: define UNCACHED_WR_ARB_DRAIN_EN to add drain_i (blocks
// new grants) and drained_o (idle with nothing in flight).
module uncached_wr_arb
  import uncached_wr_arb_pkg::*;
#(
  parameter int NrHarts        = 2,
  parameter int MaxOutstanding = 7,
  parameter int AxiIdWidth     = 4,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64
) (
  input logic              clk_i,
  input logic              rst_ni,
  uncached_wr_arb_if.master bus
`ifdef UNCACHED_WR_ARB_DRAIN_EN
  ,
  input  logic             drain_i,
  output logic             drained_o
`endif
);

  localparam int IdxW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  uncached_wr_arb_state_e state_q;
  uncached_wr_payload_t   payload_q;
  uncached_wr_payload_t   payload_d;
  logic [CntWidth-1:0]    cnt_q;
  logic                   aw_valid_q;
  logic                   w_valid_q;
  logic                   aw_done_q;
  logic                   w_done_q;

  logic                   gnt_valid;
  logic [IdxW-1:0]        gnt_idx;
  logic                   grant_en;
  logic                   can_issue;
  logic                   any_req;
  logic                   gnt_take;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   cnt_dec;
  logic                   b_underflow;

`ifdef UNCACHED_WR_ARB_DRAIN_EN
  assign grant_en  = !drain_i;
  assign drained_o = drain_i && (state_q == IDLE) && (cnt_q == '0);
`else
  assign grant_en  = 1'b1;
`endif

  assign any_req     = |bus.req_valid_i;
  assign can_issue   = cnt_q < MaxCnt;
  assign gnt_take    = (state_q == IDLE) && gnt_valid && grant_en && can_issue;
  assign aw_hs       = aw_valid_q && bus.aw_ready_i;
  assign w_hs        = w_valid_q && bus.w_ready_i;
  assign cnt_dec     = bus.b_valid_i && (cnt_q != '0);
  assign b_underflow = bus.b_valid_i && (cnt_q == '0);

  rr_grant #(
    .NrHarts (NrHarts),
    .IdxW    (IdxW)
  ) u_rr_grant (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (bus.req_valid_i),
    .take_i      (gnt_take),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Capture the winner's payload zero-extended into the shared struct.
  always_comb begin
    payload_d                      = '0;
    payload_d.addr[AddrWidth-1:0]  = bus.req_addr_i[gnt_idx];
    payload_d.data[DataWidth-1:0]  = bus.req_data_i[gnt_idx];
    payload_d.be[DataWidth/8-1:0]  = bus.req_be_i[gnt_idx];
    payload_d.hart                 = MaxHartIdxWidth'(gnt_idx);
  end

  // Ready pulses for the granted hart only while the grant is taken.
  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      bus.req_ready_o[i] = gnt_take && (gnt_idx == IdxW'(i));
    end
  end

  // Completion routing: low id bits select the hart; SLVERR/DECERR flag error.
  always_comb begin
    for (int i = 0; i < NrHarts; i++) begin
      bus.rsp_valid_o[i] = bus.b_valid_i && (bus.b_id_i[IdxW-1:0] == IdxW'(i));
    end
    bus.rsp_err_o = bus.b_valid_i && (bus.b_resp_i == 2'b10 || bus.b_resp_i == 2'b11);
  end

  // Main FSM: grant in IDLE, hold AW/W until each handshakes in ISSUE, wait
  // in STALL while the in-flight limit is reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_take) begin
            payload_q  <= payload_d;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            state_q    <= ISSUE;
          end else if (any_req && grant_en && !can_issue) begin
            state_q <= STALL;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            state_q <= IDLE;
          end
        end
        STALL: begin
          if (can_issue) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-flight count: +1 at AW handshake, -1 at B beat, unchanged on both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_next(cnt_q, aw_hs, cnt_dec);
  end

`ifndef SYNTHESIS
  logic err_underflow_q;
  logic unused_underflow;
  // Sticky debug flag: a B beat arrived with nothing in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          err_underflow_q <= 1'b0;
    else if (b_underflow) err_underflow_q <= 1'b1;
  end
  assign unused_underflow = err_underflow_q;
`else
  logic unused_underflow;
  assign unused_underflow = b_underflow;
`endif

  assign bus.aw_valid_o    = aw_valid_q;
  assign bus.aw_addr_o     = payload_q.addr[AddrWidth-1:0];
  assign bus.aw_len_o      = 8'd0;
  assign bus.w_valid_o     = w_valid_q;
  assign bus.w_data_o      = payload_q.data[DataWidth-1:0];
  assign bus.w_strb_o      = payload_q.be[DataWidth/8-1:0];
  assign bus.w_last_o      = 1'b1;
  assign bus.b_ready_o     = 1'b1;
  assign bus.outstanding_o = cnt_q;

  // AXI id carries the hart index in its low bits, zero above.
  always_comb begin
    bus.aw_id_o                      = '0;
    bus.aw_id_o[MaxHartIdxWidth-1:0] = payload_q.hart;
  end

  // Payload bits beyond the configured widths and high id bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{payload_q, bus.b_id_i};

endmodule

// File: tb/tb_uncached_wr_arb.sv
// Directed bench for uncached_wr_arb (NrHarts=2, MaxOutstanding=7).
module tb_uncached_wr_arb;
  import uncached_wr_arb_pkg::*;

  int errors = 0;
  int checks = 0;

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uncached_wr_arb_if #(.NrHarts(2), .AxiIdWidth(4), .AddrWidth(64), .DataWidth(64)) bus ();

`ifdef UNCACHED_WR_ARB_DRAIN_EN
  logic drain = 1'b0;
  logic drained;
  uncached_wr_arb #(.NrHarts(2), .MaxOutstanding(7), .AxiIdWidth(4), .AddrWidth(64),
                    .DataWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .drain_i(drain), .drained_o(drained));
`else
  uncached_wr_arb #(.NrHarts(2), .MaxOutstanding(7), .AxiIdWidth(4), .AddrWidth(64),
                    .DataWidth(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));
`endif

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.b_valid_i   = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // One complete store through hart h with both AXI readies high.
  task automatic do_store(input int h);
    bus.req_valid_i = 2'b00;
    bus.req_valid_i[h] = 1'b1;
    #1;
    `CHK("store_ready", bus.req_ready_o, bus.req_valid_i)
    cyc();
    bus.req_valid_i = 2'b00;
    cyc();
  endtask

  initial begin
    logic seen;
    logic [1:0] exp_rdy;
    logic [3:0] exp_id;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_be_i    = '0;
    bus.aw_ready_i  = 1'b0;
    bus.w_ready_i   = 1'b0;
    bus.b_valid_i   = 1'b0;
    bus.b_id_i      = '0;
    bus.b_resp_i    = 2'b00;
    repeat (2) cyc();

    // Reset values
    `CHK("rst_req_ready", bus.req_ready_o, 2'b00)
    `CHK("rst_aw_valid", bus.aw_valid_o, 1'b0)
    `CHK("rst_w_valid", bus.w_valid_o, 1'b0)
    `CHK("rst_rsp_valid", bus.rsp_valid_o, 2'b00)
    `CHK("rst_outstanding", bus.outstanding_o, 4'd0)
    `CHK("b_ready_const", bus.b_ready_o, 1'b1)
    `CHK("w_last_const", bus.w_last_o, 1'b1)
    `CHK("aw_len_zero", bus.aw_len_o, 8'd0)
    rst_n = 1'b1;

    // Single store from hart0
    bus.aw_ready_i = 1'b1;
    bus.w_ready_i  = 1'b1;
    bus.req_addr_i[0] = 64'h8000_0000;
    bus.req_data_i[0] = 64'hDEAD;
    bus.req_be_i[0]   = 8'hFF;
    bus.req_valid_i   = 2'b01;
    #1;
    `CHK("single_ready", bus.req_ready_o, 2'b01)
    cyc();
    bus.req_valid_i = 2'b00;
    `CHK("single_aw_valid", bus.aw_valid_o, 1'b1)
    `CHK("single_aw_id", bus.aw_id_o, 4'd0)
    `CHK("single_aw_addr", bus.aw_addr_o, 64'h8000_0000)
    `CHK("single_w_valid", bus.w_valid_o, 1'b1)
    `CHK("single_w_data", bus.w_data_o, 64'hDEAD)
    `CHK("single_w_strb", bus.w_strb_o, 8'hFF)
    cyc();
    `CHK("single_aw_drop", bus.aw_valid_o, 1'b0)
    `CHK("single_count1", bus.outstanding_o, 4'd1)
    bus.b_valid_i = 1'b1;
    bus.b_id_i    = 4'd0;
    #1;
    `CHK("single_rsp", bus.rsp_valid_o, 2'b01)
    `CHK("single_rsp_err", bus.rsp_err_o, 1'b0)
    cyc();
    bus.b_valid_i = 1'b0;
    `CHK("single_count0", bus.outstanding_o, 4'd0)

    // Fairness: both harts request continuously
    do_reset();
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_id  = 4'(k % 2);
      #1;
      checks++;
      if (bus.req_ready_o !== exp_rdy) begin
        errors++;
        $error("FAIL fair_ready: observed=%0h expected=%0h", bus.req_ready_o, exp_rdy);
      end
      cyc();
      checks++;
      if (bus.aw_id_o !== exp_id) begin
        errors++;
        $error("FAIL fair_aw_id: observed=%0h expected=%0h", bus.aw_id_o, exp_id);
      end
      cyc();
    end
    bus.req_valid_i = 2'b00;
    `CHK("fair_count4", bus.outstanding_o, 4'd4)
    do_reset();
    `CHK("fair_reset_count", bus.outstanding_o, 4'd0)

    // Split handshake: W ready at +1, AW ready at +3
    bus.aw_ready_i = 1'b0;
    bus.w_ready_i  = 1'b0;
    bus.req_addr_i[0] = 64'h1000;
    bus.req_data_i[0] = 64'h55;
    bus.req_valid_i   = 2'b01;
    #1;
    `CHK("split_ready", bus.req_ready_o, 2'b01)
    cyc();
    bus.req_valid_i = 2'b00;
    bus.w_ready_i   = 1'b1;
    `CHK("split_aw_p1", bus.aw_valid_o, 1'b1)
    `CHK("split_w_p1", bus.w_valid_o, 1'b1)
    cyc();
    bus.w_ready_i   = 1'b0;
    bus.req_valid_i = 2'b10;
    #1;
    `CHK("split_w_drop", bus.w_valid_o, 1'b0)
    `CHK("split_aw_hold", bus.aw_valid_o, 1'b1)
    `CHK("split_no_grant", bus.req_ready_o, 2'b00)
    `CHK("split_count0", bus.outstanding_o, 4'd0)
    cyc();
    bus.aw_ready_i = 1'b1;
    bus.w_ready_i  = 1'b1;
    `CHK("split_state_p3", dut.state_q, ISSUE)
    `CHK("split_addr_hold", bus.aw_addr_o, 64'h1000)
    cyc();
    #1;
    `CHK("split_state_idle", dut.state_q, IDLE)
    `CHK("split_aw_drop", bus.aw_valid_o, 1'b0)
    `CHK("split_count1", bus.outstanding_o, 4'd1)
    `CHK("split_h1_ready", bus.req_ready_o, 2'b10)
    cyc();
    bus.req_valid_i = 2'b00;
    `CHK("split_h1_id", bus.aw_id_o, 4'd1)
    cyc();
    `CHK("split_count2", bus.outstanding_o, 4'd2)
    bus.b_valid_i = 1'b1;
    bus.b_id_i    = 4'd1;
    bus.b_resp_i  = 2'b10;
    #1;
    `CHK("slverr_rsp", bus.rsp_valid_o, 2'b10)
    `CHK("slverr_err", bus.rsp_err_o, 1'b1)
    cyc();
    bus.b_id_i   = 4'd0;
    bus.b_resp_i = 2'b00;
    cyc();
    `CHK("two_b_count0", bus.outstanding_o, 4'd0)
    cyc();
    bus.b_valid_i = 1'b0;
    `CHK("underflow_count", bus.outstanding_o, 4'd0)
    `CHK("underflow_flag", dut.err_underflow_q, 1'b1)

    // Limit: seven stores, eighth request stalls
    do_reset();
    for (int k = 0; k < 7; k++) do_store(0);
    `CHK("limit_count7", bus.outstanding_o, 4'd7)
    bus.req_valid_i = 2'b01;
    #1;
    `CHK("limit_no_ready", bus.req_ready_o, 2'b00)
    cyc();
    `CHK("limit_stall", dut.state_q, STALL)
    `CHK("limit_stall_ready", bus.req_ready_o, 2'b00)
    cyc();
    `CHK("limit_stall_ready2", bus.req_ready_o, 2'b00)
    bus.b_valid_i = 1'b1;
    bus.b_id_i    = 4'd0;
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      cyc();
      bus.b_valid_i = 1'b0;
      #1;
      if (bus.req_ready_o == 2'b01) seen = 1'b1;
    end
    `CHK("limit_grant_2cyc", seen, 1'b1)
    cyc();
    bus.req_valid_i = 2'b00;
    cyc();
    `CHK("limit_count_back7", bus.outstanding_o, 4'd7)

    // Simultaneous AW handshake and B beat at count 3
    do_reset();
    for (int k = 0; k < 3; k++) do_store(k % 2);
    `CHK("simul_count3", bus.outstanding_o, 4'd3)
    bus.req_valid_i = 2'b01;
    cyc();
    bus.req_valid_i = 2'b00;
    bus.b_valid_i   = 1'b1;
    bus.b_id_i      = 4'd1;
    #1;
    `CHK("simul_aw_valid", bus.aw_valid_o, 1'b1)
    `CHK("simul_rsp", bus.rsp_valid_o, 2'b10)
    cyc();
    bus.b_valid_i = 1'b0;
    `CHK("simul_count_same", bus.outstanding_o, 4'd3)

    // Reset mid-ISSUE abandons the write
    do_reset();
    bus.aw_ready_i  = 1'b0;
    bus.w_ready_i   = 1'b0;
    bus.req_valid_i = 2'b01;
    cyc();
    bus.req_valid_i = 2'b00;
    `CHK("midrst_in_issue", bus.aw_valid_o, 1'b1)
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("midrst_aw", bus.aw_valid_o, 1'b0)
    `CHK("midrst_w", bus.w_valid_o, 1'b0)
    `CHK("midrst_count", bus.outstanding_o, 4'd0)
    `CHK("midrst_rsp", bus.rsp_valid_o, 2'b00)
    cyc();
    rst_n = 1'b1;
    cyc();
    `CHK("midrst_after_aw", bus.aw_valid_o, 1'b0)
    `CHK("midrst_after_state", dut.state_q, IDLE)
    bus.aw_ready_i = 1'b1;
    bus.w_ready_i  = 1'b1;

`ifdef UNCACHED_WR_ARB_DRAIN_EN
    // Drain with two writes in flight
    do_reset();
    do_store(0);
    do_store(1);
    drain = 1'b1;
    bus.req_valid_i = 2'b01;
    #1;
    `CHK("drain_no_grant", bus.req_ready_o, 2'b00)
    `CHK("drain_not_yet", drained, 1'b0)
    cyc();
    `CHK("drain_no_grant2", bus.req_ready_o, 2'b00)
    bus.b_valid_i = 1'b1;
    bus.b_id_i    = 4'd0;
    cyc();
    bus.b_id_i = 4'd1;
    #1;
    `CHK("drain_at_2nd_b", drained, 1'b0)
    cyc();
    bus.b_valid_i = 1'b0;
    `CHK("drained_rise", drained, 1'b1)
    `CHK("drain_no_grant3", bus.req_ready_o, 2'b00)
    drain = 1'b0;
    #1;
    `CHK("undrain_grant", bus.req_ready_o, 2'b01)
    cyc();
    bus.req_valid_i = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("drain_rst_aw", bus.aw_valid_o, 1'b0)
    `CHK("drain_rst_w", bus.w_valid_o, 1'b0)
    `CHK("drain_rst_ready", bus.req_ready_o, 2'b00)
    `CHK("drain_rst_count", bus.outstanding_o, 4'd0)
    cyc();
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uncached_wr_arb.md
UNCACHED_WR_ARB -- requirements
Module: uncached_wr_arb

Interface
REQ-001 Parameter NrHarts, default 2, number of requesting harts (2..4).
REQ-002 Parameter MaxOutstanding, default 7, maximum uncached writes in flight (1..15).
REQ-003 Parameter AxiIdWidth, default 4; AddrWidth, default 64; DataWidth, default 64.
REQ-004 clk_i  in  1  clock; sole clock domain.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  NrHarts  per-hart single-beat store handshake.
REQ-007 req_addr_i / req_data_i / req_be_i  in  NrHarts x AddrWidth / DataWidth / DataWidth/8  per-hart store payload.
REQ-008 rsp_valid_o  out  NrHarts  one-cycle pulse when that hart's write completes.
REQ-009 rsp_err_o  out  1  completion error, i.e. B resp SLVERR/DECERR; valid with rsp_valid_o.
REQ-010 aw_valid_o, aw_ready_i, aw_addr_o, aw_id_o  AXI AW subset; aw_len_o is always 0.
REQ-011 w_valid_o, w_ready_i, w_data_o, w_strb_o, w_last_o  AXI W subset; w_last_o is constant 1.
REQ-012 b_valid_i, b_ready_o, b_id_i, b_resp_i[1:0]  AXI B subset.
REQ-013 outstanding_o  out  4  current in-flight count.

Function
REQ-014 The FSM has three states: IDLE, ISSUE and STALL.
REQ-015 IDLE: if any req_valid_i is set and count < MaxOutstanding, grant round-robin, starting after the last granted hart; latch the payload; assert req_ready_o for the winner for one cycle; go to ISSUE.
REQ-016 IDLE: if count == MaxOutstanding with a pending request, go to STALL. STALL: return to IDLE the cycle after count drops.
REQ-017 ISSUE: drive aw_valid_o and w_valid_o together from the latched payload. Track aw_done and w_done independently; each valid drops after its own handshake.
REQ-018 ISSUE: return to IDLE in the cycle where both handshakes are done, whether in the same cycle or different cycles. The outstanding count increments at the AW handshake.
REQ-019 aw_id_o = {zero-pad, granted hart index} in the low clog2(NrHarts) bits.
REQ-020 b_ready_o is constant 1. On a B handshake:
  - rsp_valid_o[b_id_i low bits] pulses in the same cycle;
  - the count decrements.
REQ-021 Simultaneous AW handshake and B handshake leave the count unchanged.
REQ-022 A B beat with the count at 0 is ignored for counting and raises the sticky assertion flag err_underflow_q (simulation only).
REQ-023 AW and W valid, address and data hold stable until their handshake; there is no retraction.
REQ-024 The round-robin pointer updates only on a grant. It wraps from NrHarts-1 to 0.
REQ-025 Latency: req handshake to aw_valid_o is exactly 1 cycle.

Reset
REQ-026 Asynchronous assertion clears:
  - FSM to IDLE;
  - count to 0;
  - RR pointer to 0;
  - payload registers;
  - aw_done and w_done.
REQ-027 Reset output values: all valid, ready and rsp outputs are 0; outstanding_o is 0.
REQ-028 Reset mid-ISSUE abandons the transaction. No response is generated for it.

Configuration
REQ-029 With UNCACHED_WR_ARB_DRAIN_EN defined, the block adds two ports:
  - drain_i (in, 1): while high, no new grants are made;
  - drained_o (out, 1): high when drain_i is high, the FSM is in IDLE and the count is 0.
REQ-030 Without UNCACHED_WR_ARB_DRAIN_EN, neither port exists and grants are never inhibited.

Structure
REQ-031 The shared package holds:
  - the state enum uncached_wr_arb_state_e;
  - the payload struct (addr, data, be, hart);
  - the localparam for the count width.
REQ-032 The round-robin arbiter is one sub-module, rr_grant, which is combinational with a registered pointer.

Verification
REQ-033 Single store: hart0 writes 0x8000_0000 with data 0xDEAD, with aw_ready_i and w_ready_i high.
  - aw_valid_o is high at cycle +1 with aw_id_o=0.
  - outstanding_o is 1 afterwards.
  - A B beat with id 0 gives rsp_valid_o[0] and returns the count to 0.
REQ-034 Fairness: both harts request continuously. Grants alternate 0,1,0,1 and neither hart is starved.
REQ-035 Split handshake: w_ready_i is high at cycle +1 and aw_ready_i at +3. The FSM leaves ISSUE after +3, and w_valid_o drops after +1.
REQ-036 Limit: 7 stores are issued with no B beats, then an 8th request arrives.
  - The FSM enters STALL and req_ready_o stays 0.
  - After one B beat, the grant occurs within 2 cycles.
REQ-037 Simultaneous events: an AW handshake and a B beat in the same cycle at count 3 leave the count at 3.
REQ-038 Drain (macro on): drain_i is asserted with 2 writes in flight.
  - No grant is made.
  - drained_o rises in the cycle after the 2nd B beat.
  - A reset pulse mid-ISSUE returns all outputs to 0.
